// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : controller states (IDLE / SHIFT / DONE)
//   DEFAULT_WIDTH : default operand width
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fullsub_dataflow.sv
// Combinational one-bit full subtractor: a - b - bin.
//   a, b  : operand bits
//   bin   : borrow in
//   diff  : difference bit
//   bout  : borrow out
module fullsub_dataflow (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, LSB first, one bit per clock.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : request, accepted in IDLE or DONE
//   a, b        : minuend / subtrahend, captured on the accepting edge
//   busy        : high while bits are being processed
//   done        : one-cycle pulse, diff/borrow_out valid
//   diff        : result, held until the next completion
//   borrow_out  : final borrow, 1 when a < b
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, rb_q, res_q;
    logic             bin_q;
    logic [CW-1:0]    cnt_q;

    logic load, shift_en, last;
    logic cell_d, cell_bo;

    fullsub_dataflow u_cell (
        .a    (ra_q[0]),
        .b    (rb_q[0]),
        .bin  (bin_q),
        .diff (cell_d),
        .bout (cell_bo)
    );

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        last     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    last    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            // Flags follow the next state so they line up with state_q without extra decode.
            busy    <= (state_d == S_SHIFT);
            done    <= (state_d == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_q       <= '0;
            rb_q       <= '0;
            res_q      <= '0;
            bin_q      <= 1'b0;
            cnt_q      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (load) begin
            ra_q  <= a;
            rb_q  <= b;
            res_q <= '0;
            bin_q <= 1'b0;
            cnt_q <= '0;
        end else if (shift_en) begin
            ra_q  <= ra_q >> 1;
            rb_q  <= rb_q >> 1;
            res_q <= {cell_d, res_q[WIDTH-1:1]};
            bin_q <= cell_bo;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                diff       <= {cell_d, res_q[WIDTH-1:1]};
                borrow_out <= cell_bo;
            end
        end
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing `a - b` one bit per clock, LSB first, with a registered borrow. It is the subtract-direction counterpart of the dataflow full-adder cell. It wraps a combinational full-subtractor cell in a shift/borrow datapath with a start/done handshake. It sits behind any controller that needs a WIDTH-bit difference at low area cost.

## Interface
Parameters:
- `WIDTH`, 8: operand and result width in bits; legal range 2..32.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: request; sampled only in IDLE or DONE.
- `a`, in, WIDTH: minuend; captured on the accepting edge.
- `b`, in, WIDTH: subtrahend; captured on the accepting edge.
- `busy`, out, 1: high while in SHIFT.
- `done`, out, 1: one-cycle pulse; result valid.
- `diff`, out, WIDTH: `a - b` mod 2^WIDTH.
- `borrow_out`, out, 1: final borrow; 1 means a < b (unsigned).

## Operation
States:
- IDLE: waiting for a request.
- SHIFT: one bit processed per cycle.
- DONE: result presented for one cycle.

Transitions:
- IDLE → SHIFT when `start`=1.
- SHIFT → DONE after exactly WIDTH bit cycles.
- DONE → SHIFT if `start`=1 (back-to-back request accepted); otherwise DONE → IDLE.
- `start` in SHIFT is ignored; there is no queuing.

On the accepting edge:
- Load operand shift registers `ra`←`a`, `rb`←`b`.
- Clear the borrow register `bin`←0.
- Clear the bit counter and the internal result shift register.

Each SHIFT cycle:
- The cell computes `d = ra[0]^rb[0]^bin` and `bo = (~ra[0]&rb[0]) | (~(ra[0]^rb[0])&bin)`.
- `ra` and `rb` shift right by one.
- The result register shifts right with `d` entering at the MSB.
- `bin`←`bo`.
- The counter increments.

On the SHIFT→DONE edge:
- `diff` is loaded from the completed result register.
- `borrow_out`←final `bo`.

Holding and reset behaviour:
- `diff` and `borrow_out` hold their values until the next DONE edge or reset; inputs changing after acceptance have no effect.
- Reset at any time, including mid-SHIFT, aborts the operation. All outputs go to 0 and the state goes to IDLE; no `done` pulse is issued for the aborted request.

Width rules:
- The counter is `$clog2(WIDTH+1)` bits wide.
- Operands are unsigned; the signed interpretation of `diff` is the caller's concern.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, state IDLE.
- Latency: `start` sampled at edge E0. `busy` is high from E0 through edge E0+WIDTH. `done` is high for the single cycle following edge E0+WIDTH.
- Throughput: with `start` held high, one result every WIDTH+1 cycles.
- `done` is never high in two consecutive cycles.
- `busy` and `done` are mutually exclusive.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `serial_sub_pkg`:
  - state enum/localparams `S_IDLE=2'd0`, `S_SHIFT=2'd1`, `S_DONE=2'd2`;
  - `DEFAULT_WIDTH=8`.
- Sub-module `fullsub_dataflow`, purely combinational, ports (`diff`, `bout`, `a`, `b`, `bin`). Kept separate so it can be tested exhaustively on its own, like the adder cell.
- Top module: FSM, counter, shift registers, borrow flop, output registers.

## Test plan
- Reset, then `a`=100, `b`=37 with `start` for 1 cycle → after 8 cycles `done`=1, `diff`=63, `borrow_out`=0.
- `a`=37, `b`=100 → `diff`=8'hC1 (193), `borrow_out`=1.
- Edge values:
  - 0-0 → `diff`=0, `borrow_out`=0;
  - 0-1 → `diff`=8'hFF, `borrow_out`=1;
  - 255-255 → `diff`=0, `borrow_out`=0.
- Pulse `start` with new operands during SHIFT cycle 3 → ignored; the original result is reported and `done` pulses exactly once.
- Assert `rst` in SHIFT cycle 4 → all outputs 0 immediately with no `done`. A subsequent 200-55 request yields 145 with `borrow_out`=0.
- Hold `start`=1 across DONE with operands 10-3, then 3-10 → `done` pulses WIDTH+1 cycles apart with results 7/0 then 249/1.
- `fullsub_dataflow` standalone: all 8 input combinations → truth-table `diff`/`bout` match.
